// File: rtl/usb_fs_rx_sniffer.sv
// Passive USB full-speed receiver: 4x oversampling DPLL, NRZI decode, SYNC detect,
// bit unstuffing, EOP/error detection and bus-reset indication.
`timescale 1ns/1ps
module usb_fs_rx_sniffer #(
   parameter int RESET_CYCLES   = 120,
   parameter int MIN_SYNC_ZEROS = 5
) (
   input  logic       clk48_host,
   input  logic       reset_n,
   input  logic       usb_d_p,
   input  logic       usb_d_n,
   output logic [1:0] line_state,
   output logic       rx_active,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_eop,
   output logic       rx_err,
   output logic       bus_reset
);
   localparam int RW = $clog2(RESET_CYCLES + 1);
   localparam int ZW = $clog2(MIN_SYNC_ZEROS + 1);
   localparam logic [RW-1:0] RST_MAX = RW'(RESET_CYCLES);
   localparam logic [ZW-1:0] ZMAX    = ZW'(MIN_SYNC_ZEROS);

   localparam logic [1:0] LS_SE0 = 2'd0;
   localparam logic [1:0] LS_J   = 2'd1;
   localparam logic [1:0] LS_K   = 2'd2;
   localparam logic [1:0] LS_SE1 = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE, S_SYNC, S_DATA, S_EOP_WAIT, S_ABORT
   } state_t;

   state_t        state_q, state_d;
   logic          dp_meta_q, dp_meta_d, dp_sync_q, dp_sync_d;
   logic          dn_meta_q, dn_meta_d, dn_sync_q, dn_sync_d;
   logic [1:0]    ls_q, ls_d, ph_q, ph_d, prev_q, prev_d;
   logic [RW-1:0] se0_q, se0_d;
   logic [ZW-1:0] zeros_q, zeros_d;
   logic [2:0]    ones_q, ones_d, bitcnt_q, bitcnt_d, abort_j_q, abort_j_d;
   logic          abort_se0_q, abort_se0_d;
   logic [7:0]    shreg_q, shreg_d, data_q, data_d;
   logic          valid_q, valid_d, eop_q, eop_d, err_q, err_d, active_q, active_d;
   logic          samp, is_jk, bit_one;

   assign samp    = (ph_q == 2'd1);
   assign is_jk   = (ls_q == LS_J) || (ls_q == LS_K);
   assign bit_one = (ls_q == prev_q);

   // Front end: synchronizers, line state, DPLL phase, SE0 run length
   always_comb begin
      dp_meta_d = usb_d_p;
      dp_sync_d = dp_meta_q;
      dn_meta_d = usb_d_n;
      dn_sync_d = dn_meta_q;
      ls_d      = {dn_sync_q, dp_sync_q};
      ph_d      = (ls_d != ls_q) ? 2'd0 : ph_q + 2'd1;
      prev_d    = samp ? ls_q : prev_q;
      if (ls_q != LS_SE0)       se0_d = '0;
      else if (se0_q == RST_MAX) se0_d = se0_q;
      else                      se0_d = se0_q + 1'b1;
   end

   always_ff @(posedge clk48_host or negedge reset_n) begin
      if (!reset_n) begin
         dp_meta_q <= 1'b1;
         dp_sync_q <= 1'b1;
         dn_meta_q <= 1'b0;
         dn_sync_q <= 1'b0;
         ls_q      <= LS_J;
         ph_q      <= 2'd0;
         prev_q    <= LS_J;
         se0_q     <= '0;
      end else begin
         dp_meta_q <= dp_meta_d;
         dp_sync_q <= dp_sync_d;
         dn_meta_q <= dn_meta_d;
         dn_sync_q <= dn_sync_d;
         ls_q      <= ls_d;
         ph_q      <= ph_d;
         prev_q    <= prev_d;
         se0_q     <= se0_d;
      end
   end

   // FSM state register
   always_ff @(posedge clk48_host or negedge reset_n) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      if (samp) begin
         case (state_q)
            S_IDLE:     if (ls_q == LS_K) state_d = S_SYNC;
            S_SYNC: begin
               if (!is_jk)       state_d = S_IDLE;
               else if (bit_one) state_d = (zeros_q >= ZMAX) ? S_DATA : S_IDLE;
            end
            S_DATA: begin
               if (ls_q == LS_SE0)                state_d = S_EOP_WAIT;
               else if (ls_q == LS_SE1)           state_d = S_ABORT;
               else if (ones_q == 3'd6 && bit_one) state_d = S_ABORT;
            end
            S_EOP_WAIT: if (ls_q == LS_J) state_d = S_IDLE;
            S_ABORT:    if (ls_q == LS_J && (abort_se0_q || abort_j_q == 3'd7)) state_d = S_IDLE;
            default:    state_d = S_IDLE;
         endcase
      end
   end

   // FSM outputs and datapath next values
   always_comb begin
      zeros_d     = zeros_q;
      ones_d      = ones_q;
      bitcnt_d    = bitcnt_q;
      shreg_d     = shreg_q;
      data_d      = data_q;
      abort_se0_d = abort_se0_q;
      abort_j_d   = abort_j_q;
      valid_d     = 1'b0;
      eop_d       = 1'b0;
      err_d       = 1'b0;
      active_d    = (state_d == S_DATA);
      if (samp) begin
         case (state_q)
            S_IDLE: zeros_d = ZW'(1);
            S_SYNC: begin
               // SYNC's terminating 1 seeds the ones counter for stuffing
               ones_d   = 3'd1;
               bitcnt_d = 3'd0;
               if (is_jk && !bit_one && zeros_q != ZMAX) zeros_d = zeros_q + 1'b1;
            end
            S_DATA: begin
               abort_se0_d = 1'b0;
               abort_j_d   = 3'd0;
               if (ls_q == LS_SE0) begin
                  eop_d = (bitcnt_q == 3'd0);
                  err_d = (bitcnt_q != 3'd0);
               end else if (ls_q == LS_SE1) begin
                  err_d = 1'b1;
               end else if (ones_q == 3'd6) begin
                  if (bit_one) err_d  = 1'b1;
                  else         ones_d = 3'd0;
               end else begin
                  shreg_d  = {bit_one, shreg_q[7:1]};
                  ones_d   = bit_one ? ones_q + 3'd1 : 3'd0;
                  bitcnt_d = bitcnt_q + 3'd1;
                  if (bitcnt_q == 3'd7) begin
                     valid_d = 1'b1;
                     data_d  = {bit_one, shreg_q[7:1]};
                  end
               end
            end
            S_ABORT: begin
               if (ls_q == LS_SE0) begin
                  abort_se0_d = 1'b1;
                  abort_j_d   = 3'd0;
               end else if (ls_q == LS_J) begin
                  abort_j_d = abort_j_q + 3'd1;
               end else begin
                  abort_j_d = 3'd0;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk48_host or negedge reset_n) begin
      if (!reset_n) begin
         zeros_q     <= '0;
         ones_q      <= 3'd0;
         bitcnt_q    <= 3'd0;
         shreg_q     <= 8'h00;
         data_q      <= 8'h00;
         abort_se0_q <= 1'b0;
         abort_j_q   <= 3'd0;
         valid_q     <= 1'b0;
         eop_q       <= 1'b0;
         err_q       <= 1'b0;
         active_q    <= 1'b0;
      end else begin
         zeros_q     <= zeros_d;
         ones_q      <= ones_d;
         bitcnt_q    <= bitcnt_d;
         shreg_q     <= shreg_d;
         data_q      <= data_d;
         abort_se0_q <= abort_se0_d;
         abort_j_q   <= abort_j_d;
         valid_q     <= valid_d;
         eop_q       <= eop_d;
         err_q       <= err_d;
         active_q    <= active_d;
      end
   end

   assign line_state = ls_q;
   assign rx_active  = active_q;
   assign rx_data    = data_q;
   assign rx_valid   = valid_q;
   assign rx_eop     = eop_q;
   assign rx_err     = err_q;
   assign bus_reset  = (se0_q == RST_MAX);

endmodule
